// File: rtl/fe_mux_pkg.sv
// Shared definitions for the front-end mux lane receiver: parameter defaults,
// sync state encoding and the per-cycle pulse classification record.
package fe_mux_pkg;

  localparam int SYNC_PERIOD_DEF = 4;
  localparam int LOCK_COUNT_DEF  = 3;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int NIB_W           = 4;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_e;

  typedef struct packed {
    logic on_time;
    logic early;
    logic missed;
  } sync_evt_t;

endpackage

// File: rtl/fe_mux_nib_fifo.sv
// Nibble FIFO with extended pointers; the head is presented combinationally
// and forced to zero while empty.
module fe_mux_nib_fifo
  import fe_mux_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int WIDTH = NIB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the head slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  // NOTE: the array is not reset; the pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/fe_mux_lane_rx.sv
// DDR lane receiver: tracks the external frame marker, assembles two lane
// bit-pairs into a nibble per half-frame and queues nibbles for the consumer.
module fe_mux_lane_rx
  import fe_mux_pkg::*;
#(
  parameter int SYNC_PERIOD = SYNC_PERIOD_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             extclksync,
  input  logic             lane_0,
  input  logic             lane_180,
  output logic [NIB_W-1:0] nib_data,
  output logic             nib_valid,
  input  logic             nib_ready,
  output logic             locked,
  output logic [7:0]       sync_err_cnt,
  output logic             overflow,
  input  logic             clr_status
);

  localparam int PW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SYNC_PERIOD - 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_COUNT);

  sync_state_e state_q, state_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic          err_run_q, err_run_d;  // one error already seen in a row
  logic          phase_q;
  logic [PW-1:0] period_cnt_q;
  logic [1:0]    nib_lo_q;
  logic          half_valid_q;
  sync_evt_t     evt;
  logic          sync_err;
  logic          leave_lock;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;

  always_comb begin
    evt.on_time = extclksync && (period_cnt_q == PERIOD_LAST);
    evt.early   = extclksync && (period_cnt_q != PERIOD_LAST);
    evt.missed  = !extclksync && (period_cnt_q == PERIOD_LAST);
    sync_err    = evt.early || evt.missed;
  end

  // Phase and period counter keep free-running across a missed marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      phase_q      <= extclksync ? 1'b0 : ~phase_q;
      period_cnt_q <= (extclksync || evt.missed) ? '0 : period_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      good_cnt_q <= '0;
      err_run_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_run_q  <= err_run_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_run_d  = err_run_q;
    case (state_q)
      SEARCH: begin
        if (extclksync) begin
          state_d    = CHECK;
          good_cnt_d = GW'(1);
        end
      end
      CHECK: begin
        if (evt.on_time) begin
          good_cnt_d = good_cnt_q + 1'b1;
          if (good_cnt_d >= GOOD_TARGET) begin
            state_d   = LOCKED;
            err_run_d = 1'b0;
          end
        end else if (sync_err) begin
          state_d = SEARCH;
        end
      end
      LOCKED: begin
        if (evt.on_time) begin
          err_run_d = 1'b0;
        end else if (sync_err) begin
          err_run_d = !err_run_q;
          if (err_run_q) state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked     = (state_q == LOCKED);
    leave_lock = locked && (state_d != LOCKED);
    push       = phase_q && half_valid_q;
    pop        = nib_ready && !fifo_empty;
    nib_valid  = !fifo_empty;
  end

  // A partial nibble never survives loss of lock; queued nibbles do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_lo_q     <= '0;
      half_valid_q <= 1'b0;
    end else begin
      if (!phase_q && locked) nib_lo_q <= {lane_180, lane_0};
      if (leave_lock)               half_valid_q <= 1'b0;
      else if (!phase_q && locked)  half_valid_q <= 1'b1;
      else if (phase_q)             half_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_cnt <= '0;
      overflow     <= 1'b0;
    end else if (clr_status) begin
      sync_err_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (locked && sync_err && (sync_err_cnt != ERR_CNT_MAX))
        sync_err_cnt <= sync_err_cnt + 8'd1;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  fe_mux_nib_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NIB_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({lane_180, lane_0, nib_lo_q}),
    .pop   (pop),
    .dout  (nib_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_fe_mux_lane_rx.sv
// Directed bench for fe_mux_lane_rx: a vector table for lock-up and nibble
// assembly, then hand sequences for overflow, sync loss, saturation and reset.
module tb_fe_mux_lane_rx;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       extclksync = 1'b0;
  logic       lane_0     = 1'b0;
  logic       lane_180   = 1'b0;
  logic       nib_ready  = 1'b0;
  logic       clr_status = 1'b0;
  logic [3:0] nib_data;
  logic       nib_valid;
  logic       locked;
  logic [7:0] sync_err_cnt;
  logic       overflow;

  always #5 clk = ~clk;

  fe_mux_lane_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .extclksync   (extclksync),
    .lane_0       (lane_0),
    .lane_180     (lane_180),
    .nib_data     (nib_data),
    .nib_valid    (nib_valid),
    .nib_ready    (nib_ready),
    .locked       (locked),
    .sync_err_cnt (sync_err_cnt),
    .overflow     (overflow),
    .clr_status   (clr_status)
  );

  typedef struct packed {
    logic       sync;
    logic       l0;
    logic       l180;
    logic       rdy;
    logic       exp_locked;
    logic       exp_valid;
    logic [3:0] exp_data;
  } vec_t;

  vec_t vecs [20];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, let the edge happen, settle 1 ns after it.
  task automatic step(input logic s, input logic a, input logic b, input logic r, input logic c);
    extclksync = s;
    lane_0     = a;
    lane_180   = b;
    nib_ready  = r;
    clr_status = c;
    @(posedge clk);
    #1;
  endtask

  // Four-cycle frame with an on-time marker on the last cycle.
  task automatic nib_frame(input logic [3:0] n0, input logic [3:0] n1, input logic [3:0] rdy);
    step(1'b0, n0[0], n0[1], rdy[0], 1'b0);
    step(1'b0, n0[2], n0[3], rdy[1], 1'b0);
    step(1'b0, n1[0], n1[1], rdy[2], 1'b0);
    step(1'b1, n1[2], n1[3], rdy[3], 1'b0);
  endtask

  // Eight cycles: missed marker at cycle 4, on-time marker at cycle 8.
  task automatic miss_frame(input int clr_at);
    for (int i = 0; i < 8; i++) step(i == 7, 1'b0, 1'b0, 1'b1, i == clr_at);
  endtask

  initial begin
    // Fields: sync l0 l180 rdy _ locked valid _ data
    vecs[0]  = 10'b0110_00_0000;
    vecs[1]  = 10'b0100_00_0000;
    vecs[2]  = 10'b0010_00_0000;
    vecs[3]  = 10'b1110_00_0000;
    vecs[4]  = 10'b0101_00_0000;
    vecs[5]  = 10'b0110_00_0000;
    vecs[6]  = 10'b0010_00_0000;
    vecs[7]  = 10'b1110_00_0000;
    vecs[8]  = 10'b0100_00_0000;
    vecs[9]  = 10'b0110_00_0000;
    vecs[10] = 10'b0100_00_0000;
    vecs[11] = 10'b1110_10_0000;
    vecs[12] = 10'b0100_10_0000;
    vecs[13] = 10'b0110_11_1101;
    vecs[14] = 10'b0011_10_0000;
    vecs[15] = 10'b1100_11_0110;
    vecs[16] = 10'b0111_10_0000;
    vecs[17] = 10'b0010_11_1011;
    vecs[18] = 10'b0111_10_0000;
    vecs[19] = 10'b1110_11_1111;

    repeat (2) @(posedge clk);
    #1;
    check("rst nib_valid", 32'(nib_valid), 0);
    check("rst nib_data", 32'(nib_data), 0);
    check("rst locked", 32'(locked), 0);
    check("rst sync_err_cnt", 32'(sync_err_cnt), 0);
    check("rst overflow", 32'(overflow), 0);
    #2 rst_n = 1'b1;

    // Lock-up after the third marker, then nibble assembly and ordering.
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].sync, vecs[i].l0, vecs[i].l180, vecs[i].rdy, 1'b0);
      check($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].exp_locked));
      check($sformatf("vec%0d nib_valid", i), 32'(nib_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d nib_data", i), 32'(nib_data), 32'(vecs[i].exp_data));
    end

    // Overflow: FIFO holds F; pop it, then fill with 1,2,3,4 and drop 5.
    nib_frame(4'h1, 4'h2, 4'b0001);
    nib_frame(4'h3, 4'h4, 4'b0000);
    check("full head", 32'(nib_data), 32'h1);
    check("full overflow", 32'(overflow), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drop overflow", 32'(overflow), 1);
    check("drop head held", 32'(nib_data), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clr overflow", 32'(overflow), 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pop+push full overflow", 32'(overflow), 0);
    check("pop+push full head", 32'(nib_data), 32'h2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("order 3", 32'(nib_data), 32'h3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("order 4", 32'(nib_data), 32'h4);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("order 6", 32'(nib_data), 32'h6);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("order 7", 32'(nib_data), 32'h7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("order 8", 32'(nib_data), 32'h8);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("order 9", 32'(nib_data), 32'h9);

    // Sync loss: one early marker tolerated, a second consecutive one drops lock.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("early1 sync_err_cnt", 32'(sync_err_cnt), 1);
    check("early1 locked", 32'(locked), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("early2 sync_err_cnt", 32'(sync_err_cnt), 2);
    check("early2 locked", 32'(locked), 0);
    check("early2 fifo kept", 32'(nib_data), 32'h9);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("unlocked no push valid", 32'(nib_valid), 1);
    check("unlocked no push head", 32'(nib_data), 32'h9);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("partial dropped", 32'(nib_valid), 0);

    // Relock, then saturate the error counter with missed markers.
    nib_frame(4'h0, 4'h0, 4'b0000);
    nib_frame(4'h0, 4'h0, 4'b0000);
    check("relock pending", 32'(locked), 0);
    nib_frame(4'h0, 4'h0, 4'b0000);
    check("relocked", 32'(locked), 1);
    check("relock sync_err_cnt", 32'(sync_err_cnt), 2);
    miss_frame(0);
    check("clr then miss", 32'(sync_err_cnt), 1);
    repeat (253) miss_frame(-1);
    check("254 errors", 32'(sync_err_cnt), 254);
    repeat (46) miss_frame(-1);
    check("300 errors saturate", 32'(sync_err_cnt), 255);
    check("alternating stays locked", 32'(locked), 1);
    miss_frame(0);
    check("clr from sat", 32'(sync_err_cnt), 1);
    miss_frame(3);
    check("clr beats increment", 32'(sync_err_cnt), 0);
    miss_frame(-1);
    nib_frame(4'h5, 4'hA, 4'b0000);
    check("pre-reset valid", 32'(nib_valid), 1);
    check("pre-reset locked", 32'(locked), 1);
    check("pre-reset sync_err_cnt", 32'(sync_err_cnt), 1);

    // Asynchronous reset between edges with three nibbles queued.
    #1 rst_n = 1'b0;
    #1;
    check("async rst nib_valid", 32'(nib_valid), 0);
    check("async rst nib_data", 32'(nib_data), 0);
    check("async rst locked", 32'(locked), 0);
    check("async rst sync_err_cnt", 32'(sync_err_cnt), 0);
    check("async rst overflow", 32'(overflow), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("held rst nib_valid", 32'(nib_valid), 0);
    check("held rst locked", 32'(locked), 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
